// File: rtl/router_pkg.sv
// Shared encodings for the router packet FSM: state codes, destination
// addresses and a per-port flag selector.
package router_pkg;

    localparam logic [2:0] S_DA  = 3'd0;
    localparam logic [2:0] S_LFD = 3'd1;
    localparam logic [2:0] S_LD  = 3'd2;
    localparam logic [2:0] S_FFS = 3'd3;
    localparam logic [2:0] S_LAF = 3'd4;
    localparam logic [2:0] S_LP  = 3'd5;
    localparam logic [2:0] S_CPE = 3'd6;
    localparam logic [2:0] S_WTE = 3'd7;

    typedef enum logic [2:0] {
        ST_DA  = S_DA,
        ST_LFD = S_LFD,
        ST_LD  = S_LD,
        ST_FFS = S_FFS,
        ST_LAF = S_LAF,
        ST_LP  = S_LP,
        ST_CPE = S_CPE,
        ST_WTE = S_WTE
    } state_e;

    localparam logic [1:0] ADDR_0       = 2'b00;
    localparam logic [1:0] ADDR_1       = 2'b01;
    localparam logic [1:0] ADDR_2       = 2'b10;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    // Picks one port's flag; the invalid address never selects a port.
    function automatic logic sel_flag(input logic [2:0] flags, input logic [1:0] addr);
        logic f;
        f = 1'b0;
        case (addr)
            ADDR_0:  f = flags[0];
            ADDR_1:  f = flags[1];
            ADDR_2:  f = flags[2];
            default: f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Signal bundle between the packet source / sync block and the router FSM.
// Handshake: the source holds header/payload while busy=1; write_enb_reg qualifies FIFO writes.
interface router_fsm_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       write_enb_reg;
    logic       busy;

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
        output rst_int_reg, write_enb_reg, busy
    );

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
        input  rst_int_reg, write_enb_reg, busy
    );
endinterface

// File: rtl/router_pkt_counter.sv
// Counts completed packets (parity-check exit to address decode); wraps at 255.
module router_pkt_counter (
    input  logic       clk,
    input  logic       resetn,
    input  logic       inc,
    output logic [7:0] pkt_cnt
);
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) cnt_q <= 8'd0;
        else         cnt_q <= cnt_d;
    end

    assign pkt_cnt = cnt_q;
endmodule

// File: rtl/router_fsm.sv
// Router packet-control FSM with Moore state-decoded outputs.
// Optional packet counter port enabled by defining ROUTER_FSM_PKT_CNT_EN.
module router_fsm
    import router_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    router_fsm_if.slave        bus,
    output state_e             state_dbg
`ifdef ROUTER_FSM_PKT_CNT_EN
    ,
    output logic [7:0]         pkt_cnt
`endif
);
    state_e     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [2:0] empty_flags, sreset_flags;
    logic       hdr_ok;

    assign empty_flags  = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign sreset_flags = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    assign hdr_ok       = bus.pkt_valid && (bus.data_in != ADDR_INVALID);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        // A port flush aborts whatever packet is in flight on that port.
        if (state_q != ST_DA && sel_flag(sreset_flags, addr_q)) begin
            state_d = ST_DA;
        end else begin
            case (state_q)
                ST_DA: begin
                    if (hdr_ok) begin
                        addr_d  = bus.data_in;
                        state_d = sel_flag(empty_flags, bus.data_in) ? ST_LFD : ST_WTE;
                    end
                end
                ST_LFD: state_d = ST_LD;
                ST_LD: begin
                    if (bus.fifo_full)       state_d = ST_FFS;
                    else if (!bus.pkt_valid) state_d = ST_LP;
                end
                ST_FFS: if (!bus.fifo_full) state_d = ST_LAF;
                ST_LAF: begin
                    if (bus.parity_done)        state_d = ST_DA;
                    else if (bus.low_pkt_valid) state_d = ST_LP;
                    else                        state_d = ST_LD;
                end
                ST_LP:  state_d = ST_CPE;
                ST_CPE: state_d = bus.fifo_full ? ST_FFS : ST_DA;
                ST_WTE: if (sel_flag(empty_flags, addr_q)) state_d = ST_LFD;
                default: state_d = ST_DA;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_DA;
            addr_q  <= ADDR_INVALID;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.detect_add    = (state_q == ST_DA);
    assign bus.lfd_state     = (state_q == ST_LFD);
    assign bus.ld_state      = (state_q == ST_LD);
    assign bus.full_state    = (state_q == ST_FFS);
    assign bus.laf_state     = (state_q == ST_LAF);
    assign bus.rst_int_reg   = (state_q == ST_CPE);
    assign bus.write_enb_reg = (state_q == ST_LD) || (state_q == ST_LP) || (state_q == ST_LAF);
    assign bus.busy          = (state_q == ST_LFD) || (state_q == ST_FFS) || (state_q == ST_LAF) ||
                               (state_q == ST_LP)  || (state_q == ST_CPE) || (state_q == ST_WTE);
    assign state_dbg         = state_q;

`ifdef ROUTER_FSM_PKT_CNT_EN
    router_pkt_counter u_pkt_counter (
        .clk     (clk),
        .resetn  (resetn),
        .inc     ((state_q == ST_CPE) && (state_d == ST_DA)),
        .pkt_cnt (pkt_cnt)
    );
`endif
endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed scenarios plus random traffic against a
// named-state reference model. Define ROUTER_FSM_PKT_CNT_EN to cover the counter.
module tb_router_fsm;
    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] state_dbg;
`ifdef ROUTER_FSM_PKT_CNT_EN
    logic [7:0] pkt_cnt;
`endif

    router_fsm_if bus();

    router_fsm dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .state_dbg (state_dbg)
`ifdef ROUTER_FSM_PKT_CNT_EN
        ,
        .pkt_cnt   (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fails  = 0;
    string m_state  = "DA";
    int    m_addr   = 3;
    int    m_cnt    = 0;

    // Output vector order: detect_add lfd ld full laf rst_int write_enb busy
    function automatic logic [7:0] out_vec();
        return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.full_state,
                bus.laf_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
    endfunction

    function automatic logic [7:0] exp_vec(input string s);
        if (s == "DA")  return 8'b1000_0000;
        if (s == "LFD") return 8'b0100_0001;
        if (s == "LD")  return 8'b0010_0010;
        if (s == "FFS") return 8'b0001_0001;
        if (s == "LAF") return 8'b0000_1011;
        if (s == "LP")  return 8'b0000_0011;
        if (s == "CPE") return 8'b0000_0101;
        return 8'b0000_0001; // WTE
    endfunction

    // Reference model: next state from the current inputs, by rule.
    task automatic m_step();
        string    nx;
        bit [2:0] emp, sr;
        int       k;
        emp = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
        sr  = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
        if (!resetn) begin
            m_state = "DA"; m_addr = 3; m_cnt = 0;
            return;
        end
        nx = m_state;
        if (m_state != "DA" && m_addr < 3 && sr[m_addr]) nx = "DA";
        else if (m_state == "DA") begin
            k = int'(bus.data_in);
            if (bus.pkt_valid && k < 3) begin
                m_addr = k;
                nx = emp[k] ? "LFD" : "WTE";
            end
        end
        else if (m_state == "LFD") nx = "LD";
        else if (m_state == "LD")  nx = bus.fifo_full ? "FFS" : (!bus.pkt_valid ? "LP" : "LD");
        else if (m_state == "FFS") nx = bus.fifo_full ? "FFS" : "LAF";
        else if (m_state == "LAF") nx = bus.parity_done ? "DA" : (bus.low_pkt_valid ? "LP" : "LD");
        else if (m_state == "LP")  nx = "CPE";
        else if (m_state == "CPE") nx = bus.fifo_full ? "FFS" : "DA";
        else if (m_state == "WTE") nx = emp[m_addr] ? "LFD" : "WTE";
        if (m_state == "CPE" && nx == "DA") m_cnt = (m_cnt + 1) % 256;
        m_state = nx;
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pkt_valid = 0; bus.data_in = 2'b00; bus.fifo_full = 0;
        bus.fifo_empty_0 = 1; bus.fifo_empty_1 = 1; bus.fifo_empty_2 = 1;
        bus.soft_reset_0 = 0; bus.soft_reset_1 = 0; bus.soft_reset_2 = 0;
        bus.parity_done = 0; bus.low_pkt_valid = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 0;
        tick();
        resetn = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_vec() !== exp_vec("DA")) begin
            n_fails++; $display("FAIL reset_outputs: got %b want %b", out_vec(), exp_vec("DA"));
        end
`ifdef ROUTER_FSM_PKT_CNT_EN
        n_checks++;
        if (pkt_cnt !== 8'd0) begin
            n_fails++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt);
        end
`endif
    endtask

    task automatic test_lfd_ld_parity();
        string seq[5] = '{"LFD", "LD", "LP", "CPE", "DA"};
        do_reset();
        bus.pkt_valid = 1; bus.data_in = 2'b01; bus.fifo_empty_1 = 1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) bus.pkt_valid = 0;
            tick();
            n_checks++;
            if (out_vec() !== exp_vec(seq[i])) begin
                n_fails++; $display("FAIL packet_step%0d: got %b want %b (%s)", i, out_vec(), exp_vec(seq[i]), seq[i]);
            end
        end
`ifdef ROUTER_FSM_PKT_CNT_EN
        n_checks++;
        if (pkt_cnt !== 8'd1) begin
            n_fails++; $display("FAIL pkt_cnt_after_packet: got %0d want 1", pkt_cnt);
        end
`endif
    endtask

    task automatic test_fifo_full();
        string seq[7] = '{"LFD", "LD", "FFS", "FFS", "FFS", "LAF", "DA"};
        do_reset();
        bus.pkt_valid = 1; bus.data_in = 2'b00;
        for (int i = 0; i < 7; i++) begin
            bus.fifo_full   = (i >= 2 && i <= 4);
            bus.parity_done = (i == 6);
            tick();
            n_checks++;
            if (out_vec() !== exp_vec(seq[i])) begin
                n_fails++; $display("FAIL full_step%0d: got %b want %b (%s)", i, out_vec(), exp_vec(seq[i]), seq[i]);
            end
        end
        bus.parity_done = 0;
    endtask

    task automatic test_wait_empty();
        do_reset();
        bus.pkt_valid = 1; bus.data_in = 2'b10; bus.fifo_empty_2 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_vec() !== exp_vec("WTE")) begin
                n_fails++; $display("FAIL wte_hold%0d: got %b want %b", i, out_vec(), exp_vec("WTE"));
            end
        end
        bus.fifo_empty_2 = 1;
        tick();
        n_checks++;
        if (out_vec() !== exp_vec("LFD")) begin
            n_fails++; $display("FAIL wte_to_lfd: got %b want %b", out_vec(), exp_vec("LFD"));
        end
    endtask

    task automatic test_soft_reset();
        do_reset();
        bus.pkt_valid = 1; bus.data_in = 2'b10; bus.fifo_empty_2 = 0;
        tick();
        bus.data_in = 2'b00; bus.soft_reset_0 = 1;
        tick();
        n_checks++;
        if (out_vec() !== exp_vec("WTE")) begin
            n_fails++; $display("FAIL soft_reset_other_port: got %b want %b", out_vec(), exp_vec("WTE"));
        end
        bus.soft_reset_0 = 0; bus.soft_reset_2 = 1; bus.pkt_valid = 0;
        tick();
        n_checks++;
        if (out_vec() !== exp_vec("DA")) begin
            n_fails++; $display("FAIL soft_reset_own_port: got %b want %b", out_vec(), exp_vec("DA"));
        end
        bus.soft_reset_2 = 0;
    endtask

    task automatic test_invalid_and_midreset();
        do_reset();
        bus.pkt_valid = 1; bus.data_in = 2'b11;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (out_vec() !== exp_vec("DA")) begin
                n_fails++; $display("FAIL invalid_addr%0d: got %b want %b", i, out_vec(), exp_vec("DA"));
            end
        end
        bus.data_in = 2'b01;
        tick(); tick();
        bus.fifo_full = 1;
        tick();
        n_checks++;
        if (out_vec() !== exp_vec("FFS")) begin
            n_fails++; $display("FAIL reach_ffs: got %b want %b", out_vec(), exp_vec("FFS"));
        end
        resetn = 0;
        tick();
        resetn = 1;
        n_checks++;
        if (out_vec() !== exp_vec("DA")) begin
            n_fails++; $display("FAIL reset_in_ffs: got %b want %b", out_vec(), exp_vec("DA"));
        end
        bus.fifo_full = 0;
    endtask

`ifdef ROUTER_FSM_PKT_CNT_EN
    task automatic test_cnt_wrap();
        do_reset();
        for (int p = 0; p < 256; p++) begin
            bus.pkt_valid = 1; bus.data_in = 2'b00;
            tick();
            bus.pkt_valid = 0;
            tick(); tick(); tick(); tick();
            if (p == 254) begin
                n_checks++;
                if (pkt_cnt !== 8'd255) begin
                    n_fails++; $display("FAIL cnt_at_255: got %0d want 255", pkt_cnt);
                end
            end
        end
        n_checks++;
        if (pkt_cnt !== 8'd0) begin
            n_fails++; $display("FAIL cnt_wrap: got %0d want 0", pkt_cnt);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.pkt_valid     = ($urandom_range(0, 3) != 0);
            bus.data_in       = 2'($urandom_range(0, 3));
            bus.fifo_full     = ($urandom_range(0, 3) == 0);
            bus.fifo_empty_0  = $urandom_range(0, 1) == 1;
            bus.fifo_empty_1  = $urandom_range(0, 1) == 1;
            bus.fifo_empty_2  = $urandom_range(0, 1) == 1;
            bus.soft_reset_0  = ($urandom_range(0, 15) == 0);
            bus.soft_reset_1  = ($urandom_range(0, 15) == 0);
            bus.soft_reset_2  = ($urandom_range(0, 15) == 0);
            bus.parity_done   = ($urandom_range(0, 3) == 0);
            bus.low_pkt_valid = ($urandom_range(0, 3) == 0);
            resetn            = ($urandom_range(0, 49) != 0);
            tick();
            n_checks++;
            if (out_vec() !== exp_vec(m_state)) begin
                n_fails++; $display("FAIL random_cycle%0d: got %b want %b (%s)", i, out_vec(), exp_vec(m_state), m_state);
            end
`ifdef ROUTER_FSM_PKT_CNT_EN
            n_checks++;
            if (pkt_cnt !== 8'(m_cnt)) begin
                n_fails++; $display("FAIL random_cnt%0d: got %0d want %0d", i, pkt_cnt, m_cnt);
            end
`endif
        end
        resetn = 1;
    endtask

    initial begin
        idle_inputs();
        resetn = 0;
        test_reset();
        test_lfd_ld_parity();
        test_fifo_full();
        test_wait_empty();
        test_soft_reset();
        test_invalid_and_midreset();
`ifdef ROUTER_FSM_PKT_CNT_EN
        test_cnt_wrap();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
